// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types, defaults and slot-width helper for the TDM demultiplexer
package tdm_pkg;
  typedef enum logic {HUNT, RUN} state_t;
  localparam int N_CH_DEF = 4;
  localparam int W_DEF = 8;
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: frame slot counter with clear, load-to-1 and wrap flag at the last channel
module tdm_slot_counter import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int SW = slot_w(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          load1,
  output logic [SW-1:0] slot,
  output logic          wrap
);
  assign wrap = slot == SW'(N_CH - 1);
  // clear beats load, load beats advance; advancing past the last slot returns to 0
  always_ff @(posedge clk)
    if (rst || clr) slot <= '0;
    else if (load1) slot <= SW'(1);
    else if (en) slot <= wrap ? '0 : slot + 1'b1;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: locks to start-of-frame and routes interleaved beats to per-channel registers
module tdm_demux import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_valid,
  output logic              sync_err,
  output logic              locked
);
  localparam int SW = slot_w(N_CH);
  state_t state, state_nx;
  logic [SW-1:0] slot, wr_idx;
  logic [N_CH-1:0] wr_oh;
  logic wrap, sof, adv, miss, early, wr;
  tdm_slot_counter #(.N_CH(N_CH), .SW(SW)) u_slot (
    .clk(clk), .rst(rst), .en(adv), .clr(miss), .load1(sof), .slot(slot), .wrap(wrap)
  );
  // state register; locked is simply the registered RUN state
  always_ff @(posedge clk)
    if (rst) state <= HUNT;
    else state <= state_nx;
  assign locked = state == RUN;
  // beat classification: any sof restarts a frame, non-sof beats only count while locked
  always_comb begin
    sof = in_valid && in_sof;
    adv = in_valid && !in_sof && state == RUN && slot != '0;
    miss = in_valid && !in_sof && state == RUN && slot == '0;
    early = sof && state == RUN && slot != '0;
    wr = sof || adv;
    wr_idx = sof ? '0 : slot;
    wr_oh = wr ? N_CH'(1) << wr_idx : '0;
    state_nx = miss ? HUNT : sof ? RUN : state;
  end
  // channel register bank and registered event pulses
  always_ff @(posedge clk)
    if (rst) begin
      ch_data <= '0;
      ch_valid <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (wr_oh[i]) ch_data[i*W +: W] <= in_data;
      ch_valid <= wr_oh;
      frame_valid <= adv && wrap;
      sync_err <= early || miss;
    end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed scoreboard bench for tdm_demux
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W = 8;
  typedef struct {
    logic [N_CH*W-1:0] d;
    logic [N_CH-1:0] v;
    logic f;
    logic e;
    logic l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0] ch_valid;
  logic frame_valid, sync_err, locked;
  exp_t q[$];
  logic [N_CH*W-1:0] md = '0;
  logic ml = 1'b0;
  int ms = 0;
  int checks = 0;
  int failures = 0;
  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_valid(frame_valid),
    .sync_err(sync_err), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] x);
    exp_t e, o;
    e.v = '0;
    e.f = 1'b0;
    e.e = 1'b0;
    if (r) begin
      md = '0;
      ml = 1'b0;
      ms = 0;
    end else if (v) begin
      if (s) begin
        e.e = ml && ms != 0;
        md[0 +: W] = x;
        e.v[0] = 1'b1;
        ms = 1;
        ml = 1'b1;
      end else if (ml) begin
        if (ms == 0) begin
          e.e = 1'b1;
          ml = 1'b0;
        end else begin
          md[ms*W +: W] = x;
          e.v[ms] = 1'b1;
          if (ms == N_CH - 1) begin
            e.f = 1'b1;
            ms = 0;
          end else ms++;
        end
      end
    end
    e.d = md;
    e.l = ml;
    q.push_back(e);
    rst = r;
    in_valid = v;
    in_sof = s;
    in_data = x;
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("ch_data", 64'(ch_data), 64'(o.d));
    chk("ch_valid", 64'(ch_valid), 64'(o.v));
    chk("frame_valid", 64'(frame_valid), 64'(o.f));
    chk("sync_err", 64'(sync_err), 64'(o.e));
    chk("locked", 64'(locked), 64'(o.l));
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask
  task automatic beat(input logic s, input logic [W-1:0] x);
    step(1'b0, 1'b1, s, x);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    beat(1'b1, 8'hA0);
    chk("t1_v0", 64'(ch_valid), 64'h1);
    beat(1'b0, 8'hB1);
    beat(1'b0, 8'hC2);
    beat(1'b0, 8'hD3);
    chk("t1_fv", 64'({frame_valid, ch_valid}), 64'h18);
    chk("t1_data", 64'(ch_data), 64'hD3C2B1A0);
    chk("t1_locked", 64'(locked), 64'h1);
    step(1'b1, 1'b0, 1'b0, '0);
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h02);
    beat(1'b0, 8'h03);
    chk("t2_hunt", 64'({locked, ch_valid}), 64'h0);
    beat(1'b1, 8'hE0);
    chk("t2_lock", 64'(locked), 64'h1);
    beat(1'b0, 8'hE1);
    beat(1'b0, 8'hE2);
    beat(1'b0, 8'hE3);
    beat(1'b1, 8'h11);
    beat(1'b0, 8'h22);
    beat(1'b1, 8'h33);
    chk("t3_err", 64'({sync_err, frame_valid}), 64'h2);
    chk("t3_ch0", 64'(ch_data[7:0]), 64'h33);
    beat(1'b0, 8'h44);
    beat(1'b0, 8'h55);
    beat(1'b0, 8'h66);
    chk("t3_data", 64'(ch_data), 64'h66554433);
    beat(1'b0, 8'h77);
    chk("t4_err", 64'({sync_err, locked}), 64'h2);
    chk("t4_data", 64'(ch_data), 64'h66554433);
    idle();
    beat(1'b1, 8'hA0);
    idle();
    beat(1'b0, 8'hB1);
    idle();
    idle();
    beat(1'b0, 8'hC2);
    idle();
    beat(1'b0, 8'hD3);
    chk("t5_data", 64'(ch_data), 64'hD3C2B1A0);
    idle();
    chk("t5_fv_once", 64'(frame_valid), 64'h0);
    beat(1'b1, 8'h5A);
    beat(1'b0, 8'h5B);
    step(1'b1, 1'b1, 1'b0, 8'h5C);
    chk("t6_rst", 64'({ch_data, ch_valid, frame_valid, sync_err, locked}), 64'h0);
    beat(1'b1, 8'h10);
    beat(1'b0, 8'h20);
    beat(1'b0, 8'h30);
    beat(1'b0, 8'h40);
    beat(1'b1, 8'h50);
    beat(1'b0, 8'h60);
    beat(1'b0, 8'h70);
    beat(1'b0, 8'h80);
    chk("t6_data", 64'(ch_data), 64'h80706050);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
